// File: rtl/seq_mult_arbiter.sv
// -----------------------------------------------------------------------------
// seq_mult_arbiter
//
// Shares one external enable-driven sequential 8x8->16 multiplier between
// NREQ requesters. A round-robin arbiter picks a requester in IDLE, its
// operands are latched onto mul_a/mul_b, the multiplier is given one
// enable-low load cycle followed by MUL_CYCLES enable-high cycles, and the
// product on mul_c is captured into result with a one-cycle done pulse back
// to the granted requester.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   req      per-requester request level
//   a_in     operand A, requester i at [8i+7:8i]
//   b_in     operand B, same packing
//   ack      one-cycle pulse: operands of requester i latched
//   done     one-cycle pulse: result valid for requester i
//   result   last captured product, held until the next capture
//   gnt_id   index of the current/last granted requester
//   busy     high in LOAD, RUN and DONE
//   mul_en   multiplier enable (high only in RUN)
//   mul_a    multiplier operand A
//   mul_b    multiplier operand B
//   mul_c    multiplier product
// -----------------------------------------------------------------------------
module seq_mult_arbiter #(
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 8,
  parameter int IDW        = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] a_in,
  input  logic [8*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [15:0]       result,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic              mul_en,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_c
);

  // cnt only has to reach MUL_CYCLES-1.
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   cnt;
  logic            win_valid;
  logic [IDW-1:0]  win_id;
  logic            run_last;

  // Modulo-NREQ add for operands already below NREQ; avoids a real divider.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin pick: scan from rr_ptr upward, wrapping, first set bit wins.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_valid && req[wrap_add(rr_ptr, k)]) begin
        win_valid = 1'b1;
        win_id    = wrap_add(rr_ptr, k);
      end
    end
  end

  assign run_last = (state_q == S_RUN) && (cnt == CW'(MUL_CYCLES - 1));
  assign mul_en   = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (win_valid) state_d = S_LOAD;
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (run_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      ack     <= '0;
      done    <= '0;
      result  <= '0;
      gnt_id  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
    end else begin
      state_q <= state_d;
      ack     <= '0;
      done    <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            mul_a  <= 8'(a_in >> {win_id, 3'b000});
            mul_b  <= 8'(b_in >> {win_id, 3'b000});
            gnt_id <= win_id;
            rr_ptr <= wrap_add(win_id, 1);
            ack    <= NREQ'(1) << win_id;
          end
        end
        S_LOAD: cnt <= '0;
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (run_last) begin
            result <= mul_c;
            done   <= NREQ'(1) << gnt_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
